// File: rtl/i2c_axil_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_axil_regs_if
//  Brief    : AXI4-Lite slave bus bundle for the I2C command register block.
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_axil_regs_if;
   logic [3:0]  s_awaddr_i;
   logic        s_awvalid_i;
   logic        s_awready_o;
   logic [31:0] s_wdata_i;
   logic [3:0]  s_wstrb_i;
   logic        s_wvalid_i;
   logic        s_wready_o;
   logic [1:0]  s_bresp_o;
   logic        s_bvalid_o;
   logic        s_bready_i;
   logic [3:0]  s_araddr_i;
   logic        s_arvalid_i;
   logic        s_arready_o;
   logic [31:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        s_rvalid_o;
   logic        s_rready_i;

   modport slave (
      input  s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i,
             s_bready_i, s_araddr_i, s_arvalid_i, s_rready_i,
      output s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o,
             s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o
   );

   modport master (
      output s_awaddr_i, s_awvalid_i, s_wdata_i, s_wstrb_i, s_wvalid_i,
             s_bready_i, s_araddr_i, s_arvalid_i, s_rready_i,
      input  s_awready_o, s_wready_o, s_bresp_o, s_bvalid_o,
             s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o
   );
endinterface
`default_nettype wire

// File: rtl/i2c_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_axil_regs
//  Brief    : AXI4-Lite register front end with command FIFO and dispatcher
//             driving a byte-oriented I2C core.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_axil_regs #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   i2c_axil_regs_if.slave s_axil,
   output logic          send_o,
   output logic [15:0]   data_o,
   input  logic [7:0]    data_i,
   input  logic          done_i,
   input  logic          ready_i,
   output logic          irq_o
);
   localparam int         c_AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int         c_CW          = c_AW + 1;
   localparam logic [1:0] c_OKAY        = 2'b00;
   localparam logic [1:0] c_SLVERR      = 2'b10;
   localparam logic [3:0] c_ADDR_TXCMD  = 4'h0;
   localparam logic [3:0] c_ADDR_RXDATA = 4'h4;
   localparam logic [3:0] c_ADDR_STATUS = 4'h8;
   localparam logic [3:0] c_ADDR_CTRL   = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t          r_state;
   logic [15:0]     r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wptr, r_rptr;
   logic [c_CW-1:0] r_count;
   logic            r_send;
   logic [15:0]     r_data;
   logic            r_enable, r_irq_en, r_overflow, r_rx_valid, r_irq;
   logic [7:0]      r_rx_byte;
   logic            r_wready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]      r_bresp, r_rresp;
   logic [31:0]     r_rdata;

   logic            w_empty, w_full, w_busy;
   logic            w_wr_hs, w_rd_hs, w_txcmd_wr, w_push, w_pop, w_done;
   logic [4:0]      w_cnt5;
   logic [31:0]     w_rd_data;
   logic            w_unused_bits;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
   assign w_busy     = (r_state != ST_IDLE) || !w_empty;
   assign w_wr_hs    = r_wready && s_axil.s_awvalid_i && s_axil.s_wvalid_i;
   assign w_rd_hs    = r_arready && s_axil.s_arvalid_i;
   assign w_txcmd_wr = w_wr_hs && (s_axil.s_awaddr_i == c_ADDR_TXCMD);
   // Full is the pre-pop occupancy, so a push racing an issue still overflows.
   assign w_push     = w_txcmd_wr && !w_full;
   assign w_pop      = (r_state == ST_ISSUE);
   assign w_done     = (r_state == ST_WAIT) && done_i;
   assign w_cnt5     = 5'(r_count);
   assign w_unused_bits = ^{s_axil.s_wstrb_i, s_axil.s_wdata_i[31:16]};

   always_comb begin
      w_rd_data = '0;
      if (s_axil.s_araddr_i[1:0] == 2'b00) begin
         case (s_axil.s_araddr_i[3:2])
            2'd1:    w_rd_data = {23'd0, r_rx_valid, r_rx_byte};
            2'd2:    w_rd_data = {23'd0, w_cnt5[3:0], r_overflow, r_rx_valid,
                                  w_empty, w_full, w_busy};
            2'd3:    w_rd_data = {30'd0, r_irq_en, r_enable};
            default: w_rd_data = '0;
         endcase
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= s_axil.s_wdata_i[15:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_send  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_send <= 1'b0;
         case (r_state)
            ST_IDLE: if (r_enable && !w_empty && ready_i) begin
               r_state <= ST_ISSUE;
               r_send  <= 1'b1;
               r_data  <= r_mem[r_rptr];
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT:  if (done_i) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_overflow <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_byte  <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr_hs && s_axil.s_awaddr_i == c_ADDR_CTRL)
            {r_irq_en, r_enable} <= s_axil.s_wdata_i[1:0];
         if (w_txcmd_wr && w_full)
            r_overflow <= 1'b1;
         else if (w_wr_hs && s_axil.s_awaddr_i == c_ADDR_STATUS && s_axil.s_wdata_i[4])
            r_overflow <= 1'b0;
         // A completing read command wins over a same-cycle RXDATA read clear.
         if (w_done && r_data[7]) begin
            r_rx_byte  <= data_i;
            r_rx_valid <= 1'b1;
         end else if (w_rd_hs && s_axil.s_araddr_i == c_ADDR_RXDATA) begin
            r_rx_valid <= 1'b0;
         end
         r_irq <= r_irq_en && (r_rx_valid || r_overflow);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= c_OKAY;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= c_OKAY;
         r_rdata   <= '0;
      end else begin
         if (r_wready)
            r_wready <= 1'b0;
         else if (s_axil.s_awvalid_i && s_axil.s_wvalid_i && !r_bvalid)
            r_wready <= 1'b1;
         if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= ((s_axil.s_awaddr_i == c_ADDR_RXDATA) || (w_txcmd_wr && w_full))
                        ? c_SLVERR : c_OKAY;
         end else if (r_bvalid && s_axil.s_bready_i) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd_hs) begin
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rdata   <= w_rd_data;
            r_rresp   <= (s_axil.s_araddr_i[1:0] != 2'b00) ? c_SLVERR : c_OKAY;
         end else if (r_rvalid) begin
            if (s_axil.s_rready_i) begin
               r_rvalid  <= 1'b0;
               r_arready <= 1'b1;
            end
         end else begin
            r_arready <= 1'b1;
         end
      end
   end

   assign s_axil.s_awready_o = r_wready;
   assign s_axil.s_wready_o  = r_wready;
   assign s_axil.s_bvalid_o  = r_bvalid;
   assign s_axil.s_bresp_o   = r_bresp;
   assign s_axil.s_arready_o = r_arready;
   assign s_axil.s_rvalid_o  = r_rvalid;
   assign s_axil.s_rresp_o   = r_rresp;
   assign s_axil.s_rdata_o   = r_rdata;
   assign send_o             = r_send;
   assign data_o             = r_data;
   assign irq_o              = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_i2c_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_axil_regs
//  Brief    : Directed scoreboard bench for the I2C AXI4-Lite register block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_axil_regs;
   localparam int         c_DEPTH  = 4;
   localparam logic [1:0] c_OKAY   = 2'b00;
   localparam logic [1:0] c_SLVERR = 2'b10;
   localparam int         c_BUDGET = 100;

   logic        clk = 1'b0;
   logic        r_rst_n;
   logic        r_done, r_core_ready;
   logic [7:0]  r_rx_data;
   logic        w_send, w_irq;
   logic [15:0] w_cmd;

   int          checks   = 0;
   int          failures = 0;
   logic        r_prev_send = 1'b0;

   logic [1:0]  wq[$];
   string       wq_name[$];
   logic [33:0] rq[$];
   string       rq_name[$];
   logic [15:0] sq[$];

   i2c_axil_regs_if u_bus ();

   i2c_axil_regs #(.FIFO_DEPTH(c_DEPTH)) dut (
      .clk_i   (clk),
      .rst_n_i (r_rst_n),
      .s_axil  (u_bus),
      .send_o  (w_send),
      .data_o  (w_cmd),
      .data_i  (r_rx_data),
      .done_i  (r_done),
      .ready_i (r_core_ready),
      .irq_o   (w_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: actual=no event required=event within %0d cycles", name, c_BUDGET);
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [1:0] exp, input string name);
      int n;
      wq.push_back(exp);
      wq_name.push_back(name);
      @(posedge clk); #1;
      u_bus.s_awaddr_i  = addr;
      u_bus.s_wdata_i   = data;
      u_bus.s_awvalid_i = 1'b1;
      u_bus.s_wvalid_i  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(u_bus.s_awready_o && u_bus.s_wready_o) && n < c_BUDGET);
      if (!(u_bus.s_awready_o && u_bus.s_wready_o)) timeout({name, "_wready"});
      @(posedge clk); #1;
      u_bus.s_awvalid_i = 1'b0;
      u_bus.s_wvalid_i  = 1'b0;
      n = 0;
      while (!u_bus.s_bvalid_o && n < c_BUDGET) begin @(negedge clk); n++; end
      if (!u_bus.s_bvalid_o) timeout({name, "_bvalid"});
   endtask

   task automatic wait_rvalid(input string name);
      int n = 0;
      while (!u_bus.s_rvalid_o && n < c_BUDGET) begin @(negedge clk); n++; end
      if (!u_bus.s_rvalid_o) timeout({name, "_rvalid"});
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string name);
      int n;
      rq.push_back({exp_resp, exp_data});
      rq_name.push_back(name);
      @(posedge clk); #1;
      u_bus.s_araddr_i  = addr;
      u_bus.s_arvalid_i = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!u_bus.s_arready_o && n < c_BUDGET);
      if (!u_bus.s_arready_o) timeout({name, "_arready"});
      @(posedge clk); #1;
      u_bus.s_arvalid_i = 1'b0;
      wait_rvalid(name);
   endtask

   // Returns one cycle after the issue pulse, i.e. with the dispatcher in WAIT.
   task automatic wait_send(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!w_send && n < c_BUDGET);
      if (!w_send) timeout({name, "_send"});
      @(posedge clk); #1;
   endtask

   task automatic pulse_done(input logic [7:0] rx);
      r_rx_data = rx;
      r_done    = 1'b1;
      @(posedge clk); #1;
      r_done    = 1'b0;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (r_rst_n) begin
            if (u_bus.s_bvalid_o && u_bus.s_bready_i) begin
               if (wq.size() == 0) timeout("unexpected_bvalid");
               else chk(wq_name.pop_front(), 32'(u_bus.s_bresp_o), 32'(wq.pop_front()));
            end
            if (u_bus.s_rvalid_o && u_bus.s_rready_i) begin
               if (rq.size() == 0) begin
                  timeout("unexpected_rvalid");
               end else begin
                  logic [33:0] e;
                  string       nm;
                  e  = rq.pop_front();
                  nm = rq_name.pop_front();
                  chk({nm, "_rdata"}, u_bus.s_rdata_o, e[31:0]);
                  chk({nm, "_rresp"}, 32'(u_bus.s_rresp_o), 32'(e[33:32]));
               end
            end
            if (w_send) begin
               chk("send_one_cycle", 32'(r_prev_send), 32'd0);
               if (sq.size() == 0) chk("unexpected_send", 32'(w_send), 32'd0);
               else chk("send_data", 32'(w_cmd), 32'(sq.pop_front()));
            end
         end
         r_prev_send = w_send;
      end
   end

   initial begin : stimulus
      r_rst_n           = 1'b0;
      r_done            = 1'b0;
      r_core_ready      = 1'b0;
      r_rx_data         = '0;
      u_bus.s_awaddr_i  = '0;
      u_bus.s_awvalid_i = 1'b0;
      u_bus.s_wdata_i   = '0;
      u_bus.s_wstrb_i   = 4'hF;
      u_bus.s_wvalid_i  = 1'b0;
      u_bus.s_bready_i  = 1'b1;
      u_bus.s_araddr_i  = '0;
      u_bus.s_arvalid_i = 1'b0;
      u_bus.s_rready_i  = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rdata", u_bus.s_rdata_o, 32'd0);
      chk("reset_outputs", 32'({w_send, w_cmd, w_irq, u_bus.s_awready_o, u_bus.s_wready_o,
          u_bus.s_bvalid_o, u_bus.s_bresp_o, u_bus.s_arready_o, u_bus.s_rvalid_o,
          u_bus.s_rresp_o}), 32'd0);
      @(posedge clk); #1;
      r_rst_n      = 1'b1;
      r_core_ready = 1'b1;

      // Basic write command issue and hold of data_o through WAIT
      axi_write(4'hC, 32'h1, c_OKAY, "w_ctrl_en");
      sq.push_back(16'hA550);
      axi_write(4'h0, 32'hA550, c_OKAY, "w_txcmd_a550");
      wait_send("a550");
      repeat (3) @(negedge clk);
      chk("data_o_held", 32'(w_cmd), 32'h0000A550);
      chk("send_low_in_wait", 32'(w_send), 32'd0);
      @(posedge clk); #1;
      pulse_done(8'h00);
      axi_read(4'h8, 32'h004, c_OKAY, "r_status_idle");

      // Read command capturing a received byte; second read sees rx_valid cleared
      sq.push_back(16'h00D1);
      axi_write(4'h0, 32'h00D1, c_OKAY, "w_txcmd_d1");
      wait_send("d1");
      pulse_done(8'h3C);
      axi_read(4'h4, 32'h13C, c_OKAY, "r_rxdata_valid");
      axi_read(4'h4, 32'h03C, c_OKAY, "r_rxdata_cleared");
      axi_read(4'h0, 32'h0, c_OKAY, "r_txcmd_zero");
      axi_read(4'h3, 32'h0, c_SLVERR, "r_unmapped");
      axi_write(4'h4, 32'h55, c_SLVERR, "w_rxdata_err");

      // Overflow with dispatcher disabled
      axi_write(4'hC, 32'h0, c_OKAY, "w_ctrl_dis");
      for (int i = 0; i <= c_DEPTH; i++)
         axi_write(4'h0, 32'h1001 + i, (i < c_DEPTH) ? c_OKAY : c_SLVERR,
                   $sformatf("w_fill_%0d", i));
      axi_read(4'h8, 32'h093, c_OKAY, "r_status_full_ovf");
      chk("irq_masked", 32'(w_irq), 32'd0);
      axi_write(4'h8, 32'h10, c_OKAY, "w_status_clr");
      axi_read(4'h8, 32'h083, c_OKAY, "r_status_ovf_clr");

      // Reset while in WAIT with commands still queued
      sq.push_back(16'h1001);
      axi_write(4'hC, 32'h1, c_OKAY, "w_ctrl_en2");
      wait_send("pre_reset");
      r_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_mid_txn", 32'({w_send, w_cmd, w_irq}), 32'd0);
      @(posedge clk); #1;
      r_rst_n = 1'b1;
      repeat (20) @(negedge clk);
      axi_read(4'h8, 32'h004, c_OKAY, "r_status_after_rst");
      axi_read(4'hC, 32'h0, c_OKAY, "r_ctrl_after_rst");

      // Three commands dispatched in order, gated by ready_i
      r_core_ready = 1'b0;
      axi_write(4'hC, 32'h1, c_OKAY, "w_ctrl_en3");
      for (int i = 0; i < 3; i++) begin
         sq.push_back(16'h2011 + 16'(i * 16'h0011));
         axi_write(4'h0, 32'h2011 + 32'(i * 32'h0011), c_OKAY, $sformatf("w_q3_%0d", i));
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         r_core_ready = 1'b1;
         wait_send($sformatf("q3_%0d", i));
         r_core_ready = 1'b0;
         repeat (3) @(posedge clk); #1;
         pulse_done(8'h00);
      end
      axi_read(4'h8, 32'h004, c_OKAY, "r_status_drained");

      // RXDATA read colliding with completion of a read command
      r_core_ready = 1'b1;
      axi_write(4'hC, 32'h3, c_OKAY, "w_ctrl_irq");
      sq.push_back(16'h00D1);
      axi_write(4'h0, 32'h00D1, c_OKAY, "w_txcmd_d1b");
      wait_send("d1b");
      rq.push_back({c_OKAY, 32'h000});
      rq_name.push_back("r_rx_same_cycle");
      u_bus.s_araddr_i  = 4'h4;
      u_bus.s_arvalid_i = 1'b1;
      r_rx_data         = 8'h5A;
      r_done            = 1'b1;
      @(posedge clk); #1;
      u_bus.s_arvalid_i = 1'b0;
      r_done            = 1'b0;
      wait_rvalid("r_rx_same_cycle");
      repeat (2) @(negedge clk);
      chk("irq_set", 32'(w_irq), 32'd1);
      axi_read(4'h4, 32'h15A, c_OKAY, "r_rx_after");
      repeat (3) @(negedge clk);
      chk("irq_clear", 32'(w_irq), 32'd0);

      repeat (5) @(negedge clk);
      chk("send_queue_drained", 32'(sq.size()), 32'd0);
      chk("bresp_queue_drained", 32'(wq.size()), 32'd0);
      chk("rresp_queue_drained", 32'(rq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
